fc_classifier: RTL and testbench
================================

// Module: fc_classifier
// PURPOSE
//  Final dense stage, directly downstream of the conv/maxpool/flatten engine.
//  Once start is seen, reads the N_IN flattened 5-bit signed features from the layer-2 memory bank.
//  Computes N_CLASS dot products against constant weights, adds bias, and reports the arg-max class and its score.
//  Shares the engine's memory read bus (crd/caddr_rd/csel/cdata_rd); only drives that bus while busy.
// PARAMETERS
//  N_IN     8          flattened features read (addresses 0..N_IN-1 of bank L2_SEL)
//  N_CLASS  4          number of output classes
//  CID_W    2          width of class_id (>= clog2(N_CLASS))
//  DW       5          feature/weight/bias width, signed two's complement
//  FRAC     3          bias is aligned as bias<<FRAC before accumulation
//  ACC_W    13         accumulator/score width, signed
//  L2_SEL   3'b101     csel value selecting the flattened-feature bank
//  WEIGHTS  all 0      packed N_CLASS*N_IN*DW bits; w[c][i] at bits [(c*N_IN+i)*DW +: DW]
//  BIASES   all 0      packed N_CLASS*DW bits; b[c] at bits [c*DW +: DW]
// PORTS
//  clk         in   1      clock, rising edge
//  reset       in   1      asynchronous, active-high
//  start       in   1      request; sampled only in IDLE
//  busy        out  1      high from cycle after accepted start until the done cycle (inclusive of done)
//  crd         out  1      memory read enable
//  caddr_rd    out  4      memory read address
//  csel        out  3      bank select: L2_SEL while busy, 3'b000 otherwise
//  cdata_rd    in   DW     read data, signed; valid the cycle after caddr_rd/crd presented
//  done        out  1      one-cycle pulse: class_id/score valid
//  class_id    out  CID_W  arg-max class, held until next done
//  score       out  ACC_W  winning accumulator value, held until next done
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, feature buffer/accumulators 0. Async reset mid-operation aborts immediately.
//  After reset deasserts, the next start runs normally.
//  FSM: IDLE -> LOAD -> MAC -> CMP -> DONE -> IDLE.
//   IDLE: start=1 -> LOAD. start is ignored in all other states (no queuing).
//   LOAD: N_IN+1 cycles. crd=1 for the first N_IN cycles; caddr_rd = 0,1,...,N_IN-1 registered.
//    Feature i is captured the cycle after its address; last cycle drains only (crd=0).
//   MAC: N_CLASS*N_IN cycles, one product per cycle, class-major (c=0 i=0..N_IN-1, then c=1 ...).
//    At i=0: acc = sext(b[c])<<FRAC + w[c][0]*x[0]; otherwise acc += w[c][i]*x[i].
//    Products are DW x DW signed (2*DW bits), sign-extended to ACC_W.
//    With defaults, max |acc| = 8*256+128 = 2176 < 4096, so overflow is impossible. No saturation.
//    At the end of each class, its acc is compared to the best so far. Class 0 always initialises best.
//    A later class replaces best only if strictly greater (ties keep the lower index).
//   CMP: 1 cycle to fold the last class into best.
//   DONE: done=1, class_id/score updated this cycle, busy=1; then busy=0 and IDLE.
//  Latency: done is high exactly N_IN+N_CLASS*N_IN+3 cycles after the edge that samples start (43 at defaults).
//  crd=0 and caddr_rd=0 outside LOAD. csel=L2_SEL for the whole busy window.
//  Back-to-back: start held high during DONE is ignored; start in the following IDLE cycle begins a new run.
// TESTING
//  T1 bias only: features all 0, W=0, BIASES={0,3,-1,2}(c3..c0) -> class_id=2, score=24, done at cycle 43.
//  T2 single class: features all 1, w[1][*]=2, others 0, B=0 -> class_id=1, score=16.
//  T3 tie: W=0, B=0, any features -> class_id=0, score=0; a tie between c1 and c3 -> c1 wins.
//  T4 extremes: features all -16, w[3][*]=-16, b[3]=15, others 0 -> class_id=3, score=2168, no wrap.
//  T5 reset mid-MAC at cycle 20 -> busy/done/crd/csel=0 at once; fresh start gives the correct T2 result.
//  T6 bus check: caddr_rd sequence 0..7 with crd=1 on exactly 8 cycles; start pulses while busy are ignored.

Source files
------------

// File: rtl/fc_classifier.sv
// fc_classifier: final dense layer of the inference engine.
// On start, the block reads N_IN flattened signed features from the L2 bank
// over the shared read bus. It then runs N_CLASS dot products, one product
// per cycle, against constant weights plus a shifted bias. It reports the
// arg-max class and its score. Ties keep the lower class index.
module fc_classifier #(
    parameter int                          N_IN    = 8,
    parameter int                          N_CLASS = 4,
    parameter int                          CID_W   = 2,
    parameter int                          DW      = 5,
    parameter int                          FRAC    = 3,
    parameter int                          ACC_W   = 13,
    parameter logic [2:0]                  L2_SEL  = 3'b101,
    parameter logic [N_CLASS*N_IN*DW-1:0]  WEIGHTS = {(N_CLASS*N_IN*DW){1'b0}},
    parameter logic [N_CLASS*DW-1:0]       BIASES  = {(N_CLASS*DW){1'b0}}
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_start,
    output logic                    o_busy,
    output logic                    o_crd,
    output logic [3:0]              o_caddr_rd,
    output logic [2:0]              o_csel,
    input  logic [DW-1:0]           i_cdata_rd,
    output logic                    o_done,
    output logic [CID_W-1:0]        o_class_id,
    output logic [ACC_W-1:0]        o_score
);

    // The load counter must reach N_IN (drain cycle); the feature index only spans N_IN.
    localparam int CNT_W = $clog2(N_IN + 1);
    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_MAC  = 3'd2,
        S_CMP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [CNT_W-1:0]         r_cnt;
    logic [CID_W-1:0]         r_cls;
    logic signed [DW-1:0]     r_feat [N_IN];
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  r_best;
    logic [CID_W-1:0]         r_best_id;

    logic [IDX_W-1:0]         w_idx;
    logic [IDX_W-1:0]         w_ld_idx;
    logic [CNT_W:0]           w_ld_next;
    logic                     w_rd_more;
    logic signed [DW-1:0]     w_wt;
    logic signed [DW-1:0]     w_x;
    logic signed [DW-1:0]     w_bias;
    logic signed [2*DW-1:0]   w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_bias_sh;
    logic                     w_fold_en;
    logic [CID_W-1:0]         w_fold_id;
    logic                     w_take;
    logic signed [ACC_W-1:0]  w_best_n;
    logic [CID_W-1:0]         w_best_id_n;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode: start only counts in IDLE, every other state is fixed-length.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next = S_LOAD;
                else         w_next = S_IDLE;
            end
            S_LOAD: begin
                if (r_cnt == CNT_W'(N_IN)) w_next = S_MAC;
                else                       w_next = S_LOAD;
            end
            S_MAC: begin
                if ((r_cls == CID_W'(N_CLASS - 1)) && (r_cnt == CNT_W'(N_IN - 1))) w_next = S_CMP;
                else                                                               w_next = S_MAC;
            end
            S_CMP:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath decode: weight/feature/bias selection, product, and arg-max fold.
    always_comb begin
        w_idx      = r_cnt[IDX_W-1:0];
        w_ld_idx   = IDX_W'(r_cnt - CNT_W'(1));
        w_ld_next  = (r_state == S_IDLE) ? {(CNT_W+1){1'b0}} : ((CNT_W+1)'(r_cnt) + (CNT_W+1)'(1));
        w_rd_more  = (w_ld_next < (CNT_W+1)'(N_IN));
        w_wt       = WEIGHTS[(int'(r_cls) * N_IN + int'(w_idx)) * DW +: DW];
        w_x        = r_feat[w_idx];
        w_bias     = BIASES[int'(r_cls) * DW +: DW];
        w_prod     = w_wt * w_x;
        w_prod_ext = {{(ACC_W - 2*DW){w_prod[2*DW-1]}}, w_prod};
        w_bias_sh  = {{(ACC_W - DW){w_bias[DW-1]}}, w_bias} <<< FRAC;
        // A class finishes on the cycle before the next class starts; the last one folds in CMP.
        w_fold_en  = ((r_state == S_MAC) && (r_cnt == {CNT_W{1'b0}}) && (r_cls != {CID_W{1'b0}}))
                     || (r_state == S_CMP);
        if (r_state == S_CMP) w_fold_id = CID_W'(N_CLASS - 1);
        else                  w_fold_id = r_cls - CID_W'(1);
        // Class 0 always seeds the best; later classes must be strictly greater.
        w_take     = (w_fold_id == {CID_W{1'b0}}) || (r_acc > r_best);
        if (w_fold_en && w_take) begin
            w_best_n    = r_acc;
            w_best_id_n = w_fold_id;
        end else begin
            w_best_n    = r_best;
            w_best_id_n = r_best_id;
        end
    end

    // Counters, feature capture, accumulation and running best.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= {CNT_W{1'b0}};
            r_cls     <= {CID_W{1'b0}};
            r_acc     <= {ACC_W{1'b0}};
            r_best    <= {ACC_W{1'b0}};
            r_best_id <= {CID_W{1'b0}};
            for (int i = 0; i < N_IN; i++) begin
                r_feat[i] <= {DW{1'b0}};
            end
        end else begin
            r_best    <= w_best_n;
            r_best_id <= w_best_id_n;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= {CNT_W{1'b0}};
                    r_cls <= {CID_W{1'b0}};
                end
                S_LOAD: begin
                    // Read data trails its address by one cycle, hence the index-1 capture.
                    if (r_cnt != {CNT_W{1'b0}}) begin
                        r_feat[w_ld_idx] <= i_cdata_rd;
                    end
                    if (r_cnt == CNT_W'(N_IN)) r_cnt <= {CNT_W{1'b0}};
                    else                       r_cnt <= r_cnt + CNT_W'(1);
                end
                S_MAC: begin
                    if (r_cnt == {CNT_W{1'b0}}) r_acc <= w_bias_sh + w_prod_ext;
                    else                        r_acc <= r_acc + w_prod_ext;
                    if (r_cnt == CNT_W'(N_IN - 1)) begin
                        r_cnt <= {CNT_W{1'b0}};
                        r_cls <= r_cls + CID_W'(1);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt <= {CNT_W{1'b0}};
                    r_cls <= {CID_W{1'b0}};
                end
            endcase
        end
    end

    // Registered outputs, driven from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_busy     <= 1'b0;
            o_csel     <= 3'b000;
            o_crd      <= 1'b0;
            o_caddr_rd <= 4'd0;
            o_done     <= 1'b0;
            o_class_id <= {CID_W{1'b0}};
            o_score    <= {ACC_W{1'b0}};
        end else begin
            o_busy <= (w_next != S_IDLE);
            o_csel <= (w_next != S_IDLE) ? L2_SEL : 3'b000;
            if ((w_next == S_LOAD) && w_rd_more) begin
                o_crd      <= 1'b1;
                o_caddr_rd <= 4'(w_ld_next);
            end else begin
                o_crd      <= 1'b0;
                o_caddr_rd <= 4'd0;
            end
            o_done <= (w_next == S_DONE);
            if (w_next == S_DONE) begin
                o_class_id <= w_best_id_n;
                o_score    <= w_best_n;
            end else begin
                o_class_id <= o_class_id;
                o_score    <= o_score;
            end
        end
    end

endmodule

// File: tb/tb_fc_classifier.sv
// Testbench for fc_classifier. Five instances run side by side with different
// weight/bias sets over one shared feature memory. Each instance has its own
// registered read port. A vector table selects the feature pattern and the
// instance to check. Hand-written sequences cover reset, abort and start
// pulses that arrive while the block is busy.
module tb_fc_classifier;

    localparam int NI = 5;

    // Fills every weight of class c with value v.
    function automatic logic [159:0] wrow(input int c, input logic [4:0] v);
        logic [159:0] r;
        r = 160'd0;
        for (int i = 0; i < 8; i++) r[(c*8+i)*5 +: 5] = v;
        return r;
    endfunction

    localparam logic [159:0] W_ZERO = 160'd0;
    localparam logic [159:0] W_T2   = wrow(1, 5'd2);
    localparam logic [159:0] W_T4   = wrow(3, 5'h10);
    localparam logic [159:0] W_TIE  = wrow(1, 5'd1) | wrow(3, 5'd1);
    localparam logic [19:0]  B_ZERO = 20'd0;
    localparam logic [19:0]  B_T1   = {5'd0, 5'd3, 5'h1F, 5'd2};
    localparam logic [19:0]  B_T4   = {5'd15, 15'd0};

    logic        clk;
    logic        reset;
    logic        i_start;
    logic        busy_a  [NI];
    logic        crd_a   [NI];
    logic [3:0]  addr_a  [NI];
    logic [2:0]  csel_a  [NI];
    logic [4:0]  data_a  [NI];
    logic        done_a  [NI];
    logic [1:0]  cid_a   [NI];
    logic [12:0] score_a [NI];
    logic [4:0]  mem     [8];

    int n_tests = 0;
    int n_fail  = 0;

    fc_classifier #(.WEIGHTS(W_ZERO), .BIASES(B_ZERO)) u_z (
        .clk(clk), .reset(reset), .i_start(i_start), .o_busy(busy_a[0]), .o_crd(crd_a[0]),
        .o_caddr_rd(addr_a[0]), .o_csel(csel_a[0]), .i_cdata_rd(data_a[0]), .o_done(done_a[0]),
        .o_class_id(cid_a[0]), .o_score(score_a[0]));
    fc_classifier #(.WEIGHTS(W_ZERO), .BIASES(B_T1)) u_t1 (
        .clk(clk), .reset(reset), .i_start(i_start), .o_busy(busy_a[1]), .o_crd(crd_a[1]),
        .o_caddr_rd(addr_a[1]), .o_csel(csel_a[1]), .i_cdata_rd(data_a[1]), .o_done(done_a[1]),
        .o_class_id(cid_a[1]), .o_score(score_a[1]));
    fc_classifier #(.WEIGHTS(W_T2), .BIASES(B_ZERO)) u_t2 (
        .clk(clk), .reset(reset), .i_start(i_start), .o_busy(busy_a[2]), .o_crd(crd_a[2]),
        .o_caddr_rd(addr_a[2]), .o_csel(csel_a[2]), .i_cdata_rd(data_a[2]), .o_done(done_a[2]),
        .o_class_id(cid_a[2]), .o_score(score_a[2]));
    fc_classifier #(.WEIGHTS(W_T4), .BIASES(B_T4)) u_t4 (
        .clk(clk), .reset(reset), .i_start(i_start), .o_busy(busy_a[3]), .o_crd(crd_a[3]),
        .o_caddr_rd(addr_a[3]), .o_csel(csel_a[3]), .i_cdata_rd(data_a[3]), .o_done(done_a[3]),
        .o_class_id(cid_a[3]), .o_score(score_a[3]));
    fc_classifier #(.WEIGHTS(W_TIE), .BIASES(B_ZERO)) u_tie (
        .clk(clk), .reset(reset), .i_start(i_start), .o_busy(busy_a[4]), .o_crd(crd_a[4]),
        .o_caddr_rd(addr_a[4]), .o_csel(csel_a[4]), .i_cdata_rd(data_a[4]), .o_done(done_a[4]),
        .o_class_id(cid_a[4]), .o_score(score_a[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read feature memory, one read port per instance.
    always_ff @(posedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (crd_a[g]) data_a[g] <= mem[addr_a[g][2:0]];
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic load_mem(input int base, input int step);
        for (int i = 0; i < 8; i++) mem[i] = 5'(base + step * i);
    endtask

    // One start/run on instance k. Cycle 1 is the cycle right after the edge that samples start.
    // With poke set, start is also pulsed in cycle 5 and during the done cycle; both must be ignored.
    task automatic run(input int k, input bit poke, output int done_cyc, output int cid, output int sc);
        int rd_cnt;
        int aerr;
        int berr;
        rd_cnt   = 0;
        aerr     = 0;
        berr     = 0;
        done_cyc = 0;
        cid      = -1;
        sc       = -99999;
        @(negedge clk);
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (crd_a[k] === 1'b1) begin
                if (int'(addr_a[k]) != rd_cnt) aerr++;
                rd_cnt++;
            end else if (addr_a[k] !== 4'd0) begin
                aerr++;
            end
            if ((busy_a[k] !== 1'b1) || (csel_a[k] !== 3'b101)) berr++;
            if (done_a[k] === 1'b1) begin
                done_cyc = c;
                cid      = int'(cid_a[k]);
                sc       = int'($signed(score_a[k]));
            end
            i_start = poke && ((c == 5) || (done_a[k] === 1'b1));
            @(posedge clk);
            #1;
            i_start = 1'b0;
            if (done_cyc != 0) break;
        end
        chk("bus_rd_count", rd_cnt, 8);
        chk("bus_addr_seq", aerr, 0);
        chk("busy_csel_window", berr, 0);
        chk("idle_busy_after_done", int'(busy_a[k]), 0);
        chk("idle_csel_after_done", int'(csel_a[k]), 0);
        chk("done_one_pulse", int'(done_a[k]), 0);
        if (poke) begin
            @(posedge clk);
            #1;
            chk("start_in_done_ignored", int'(busy_a[k]), 0);
        end
    endtask

    typedef struct {
        int base;
        int step;
        int inst;
        int exp_id;
        int exp_sc;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int dc;
        int cid;
        int sc;
        string tag;

        // inst: 0 zero, 1 bias-only, 2 w[1]=2, 3 w[3]=-16 b[3]=15, 4 w[1]=w[3]=1
        tbl[0]  = '{0,   0, 1, 2, 24};
        tbl[1]  = '{0,   0, 0, 0, 0};
        tbl[2]  = '{1,   0, 2, 1, 16};
        tbl[3]  = '{1,   0, 0, 0, 0};
        tbl[4]  = '{1,   0, 4, 1, 8};
        tbl[5]  = '{-1,  0, 4, 0, 0};
        tbl[6]  = '{-16, 0, 3, 3, 2168};
        tbl[7]  = '{1,   0, 3, 0, 0};
        tbl[8]  = '{-1,  0, 2, 0, 0};
        tbl[9]  = '{0,   1, 2, 1, 56};
        tbl[10] = '{0,   1, 3, 0, 0};
        tbl[11] = '{0,   1, 4, 1, 28};
        tbl[12] = '{1,   0, 1, 2, 24};

        i_start = 1'b0;
        reset   = 1'b1;
        load_mem(0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  int'(busy_a[0]),  0);
        chk("rst_done",  int'(done_a[0]),  0);
        chk("rst_crd",   int'(crd_a[0]),   0);
        chk("rst_addr",  int'(addr_a[0]),  0);
        chk("rst_csel",  int'(csel_a[0]),  0);
        chk("rst_cid",   int'(cid_a[1]),   0);
        chk("rst_score", int'(score_a[1]), 0);
        @(negedge clk);
        reset = 1'b0;
        // start is ignored while reset is still being released? no: plain idle check
        repeat (2) @(posedge clk);
        #1;
        chk("idle_no_start_busy", int'(busy_a[0]), 0);

        for (int t = 0; t < 13; t++) begin
            load_mem(tbl[t].base, tbl[t].step);
            run(tbl[t].inst, (t == 0), dc, cid, sc);
            tag = $sformatf("vec%0d", t);
            chk({tag, "_latency"},  dc,  43);
            chk({tag, "_class_id"}, cid, tbl[t].exp_id);
            chk({tag, "_score"},    sc,  tbl[t].exp_sc);
        end

        // Reset mid-MAC aborts at once and clears held results; a fresh start then runs cleanly.
        load_mem(1, 0);
        @(negedge clk);
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        chk("abort_busy_before", int'(busy_a[2]), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_busy",  int'(busy_a[2]),  0);
        chk("abort_done",  int'(done_a[2]),  0);
        chk("abort_crd",   int'(crd_a[2]),   0);
        chk("abort_csel",  int'(csel_a[2]),  0);
        chk("abort_cid",   int'(cid_a[2]),   0);
        chk("abort_score", int'(score_a[2]), 0);
        @(negedge clk);
        reset = 1'b0;
        run(2, 1'b0, dc, cid, sc);
        chk("after_abort_latency",  dc,  43);
        chk("after_abort_class_id", cid, 1);
        chk("after_abort_score",    sc,  16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
